// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, position type and axis helpers.
package vga_timing_pkg;

    localparam int unsigned POS_W = 10;

    typedef logic [POS_W-1:0] vga_pos_t;

    // Axis layout: display, front porch, sync pulse, back porch.
    function automatic int unsigned axis_total(input int unsigned disp, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    function automatic int unsigned axis_sync_start(input int unsigned disp,
                                                    input int unsigned front);
        return disp + front;
    endfunction

    // Last position (inclusive) where sync is asserted.
    function automatic int unsigned axis_sync_end(input int unsigned disp, input int unsigned front,
                                                  input int unsigned sync);
        return disp + front + sync - 1;
    endfunction

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_BOTTOM  = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_TOP     = 33;

    localparam int unsigned H_TOTAL      = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned H_SYNC_START = axis_sync_start(H_DISPLAY, H_FRONT);
    localparam int unsigned H_SYNC_END   = axis_sync_end(H_DISPLAY, H_FRONT, H_SYNC);
    localparam int unsigned V_TOTAL      = axis_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
    localparam int unsigned V_SYNC_START = axis_sync_start(V_DISPLAY, V_BOTTOM);
    localparam int unsigned V_SYNC_END   = axis_sync_end(V_DISPLAY, V_BOTTOM, V_SYNC);

endpackage

// File: rtl/vga_hvsync_generator_if.sv
// Raster timing bundle from the sync generator to pixel/frame logic.
//   hsync, vsync : active-low sync pulses
//   display_on   : beam inside the visible region
//   hpos, vpos   : current beam position
interface vga_hvsync_generator_if;

    logic                      hsync;
    logic                      vsync;
    logic                      display_on;
    vga_timing_pkg::vga_pos_t  hpos;
    vga_timing_pkg::vga_pos_t  vpos;

    modport master (
        output hsync,
        output vsync,
        output display_on,
        output hpos,
        output vpos
    );

    modport slave (
        input hsync,
        input vsync,
        input display_on,
        input hpos,
        input vpos
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and active decode.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the position this clock
//   pos        : current position (registered)
//   wrap_c     : en && pos is the last position of the axis
//   sync_n     : active-low sync, registered from the next position so it aligns with pos
//   active_c   : pos inside the display region
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned DISPLAY = H_DISPLAY,
    parameter int unsigned FRONT   = H_FRONT,
    parameter int unsigned SYNC    = H_SYNC,
    parameter int unsigned BACK    = H_BACK
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    output vga_pos_t pos,
    output logic     wrap_c,
    output logic     sync_n,
    output logic     active_c
);

    localparam int unsigned TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

    localparam vga_pos_t LAST       = POS_W'(TOTAL - 1);
    localparam vga_pos_t SYNC_LO    = POS_W'(axis_sync_start(DISPLAY, FRONT));
    localparam vga_pos_t SYNC_HI    = POS_W'(axis_sync_end(DISPLAY, FRONT, SYNC));
    localparam vga_pos_t ACTIVE_END = POS_W'(DISPLAY);

    vga_pos_t pos_nxt_c;

    // Next position: hold, increment, or wrap to zero at the end of the axis.
    always_comb begin
        pos_nxt_c = pos;
        if (en) begin
            pos_nxt_c = (pos == LAST) ? '0 : pos + POS_W'(1);
        end
    end

    assign wrap_c   = en && (pos == LAST);
    assign active_c = (pos < ACTIVE_END);

    // Position and sync registers; sync decodes the incoming position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos    <= '0;
            sync_n <= 1'b1;
        end else begin
            pos    <= pos_nxt_c;
            sync_n <= !((pos_nxt_c >= SYNC_LO) && (pos_nxt_c <= SYNC_HI));
        end
    end

endmodule

// File: rtl/vga_hvsync_generator.sv
// VGA raster timing generator: horizontal and vertical axis counters.
//   clk   : pixel clock
//   rst_n : synchronous active-low reset, returns the beam to (0,0)
//   vid   : hsync/vsync/display_on/hpos/vpos, all describing the same pixel
module vga_hvsync_generator #(
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_BOTTOM  = vga_timing_pkg::V_BOTTOM,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_TOP     = vga_timing_pkg::V_TOP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vga_hvsync_generator_if.master        vid
);

    vga_timing_pkg::vga_pos_t h_pos;
    vga_timing_pkg::vga_pos_t v_pos;
    logic h_wrap_c;
    logic h_sync_n;
    logic h_active_c;
    logic v_sync_n;
    logic v_active_c;
    // Frame wrap is recoverable from (hpos,vpos)==(0,0) downstream.
    logic unused_v_wrap_c;

    // Horizontal axis: advances every pixel clock.
    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .pos      (h_pos),
        .wrap_c   (h_wrap_c),
        .sync_n   (h_sync_n),
        .active_c (h_active_c)
    );

    // Vertical axis: advances once per line, on the horizontal wrap.
    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_BOTTOM),
        .SYNC    (V_SYNC),
        .BACK    (V_TOP)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (h_wrap_c),
        .pos      (v_pos),
        .wrap_c   (unused_v_wrap_c),
        .sync_n   (v_sync_n),
        .active_c (v_active_c)
    );

    assign vid.hpos       = h_pos;
    assign vid.vpos       = v_pos;
    assign vid.hsync      = h_sync_n;
    assign vid.vsync      = v_sync_n;
    assign vid.display_on = h_active_c && v_active_c;

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench for vga_hvsync_generator: full 640x480 instance for line-level timing and
// reset, plus a scaled-geometry instance so whole frames fit in a short run.
module tb_vga_hvsync_generator;

    // Scaled geometry: 30 clocks per line, 17 lines per frame, 510 clocks per frame.
    localparam int unsigned SH_D = 16, SH_F = 4, SH_S = 6, SH_B = 4;
    localparam int unsigned SV_D = 8,  SV_F = 3, SV_S = 2, SV_B = 4;
    localparam int unsigned S_FRAME = (SH_D + SH_F + SH_S + SH_B) * (SV_D + SV_F + SV_S + SV_B);

    logic clk = 1'b0;
    logic rst_full_n;
    logic rst_small_n;

    always #5 clk = ~clk;

    vga_hvsync_generator_if vf ();
    vga_hvsync_generator_if vs ();

    vga_hvsync_generator dut_full (
        .clk   (clk),
        .rst_n (rst_full_n),
        .vid   (vf)
    );

    vga_hvsync_generator #(
        .H_DISPLAY (SH_D), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
        .V_DISPLAY (SV_D), .V_BOTTOM (SV_F), .V_SYNC (SV_S), .V_TOP (SV_B)
    ) dut_small (
        .clk   (clk),
        .rst_n (rst_small_n),
        .vid   (vs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the beam position is the number of clocks since reset, folded into the raster.
    function automatic void model(input int unsigned t,
                                  input int unsigned hd, input int unsigned hf,
                                  input int unsigned hs, input int unsigned hb,
                                  input int unsigned vd, input int unsigned vf_,
                                  input int unsigned vs_, input int unsigned vb,
                                  output int unsigned h, output int unsigned v,
                                  output logic hsn, output logic vsn, output logic de);
        int unsigned ht;
        int unsigned vt;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf_ + vs_ + vb;
        h   = t % ht;
        v   = (t / ht) % vt;
        hsn = !(h >= hd + hf && h < hd + hf + hs);
        vsn = !(v >= vd + vf_ && v < vd + vf_ + vs_);
        de  = (h < hd) && (v < vd);
    endfunction

    int unsigned t_full  = 0;
    int unsigned t_small = 0;
    bit          ok_full  = 1'b0;
    bit          ok_small = 1'b0;

    always @(posedge clk) begin
        if (!rst_full_n) begin
            t_full  <= 0;
            ok_full <= 1'b1;
        end else begin
            t_full <= t_full + 1;
        end
        if (!rst_small_n) begin
            t_small  <= 0;
            ok_small <= 1'b1;
        end else begin
            t_small <= t_small + 1;
        end
    end

    // Every-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        int unsigned h, v;
        logic hsn, vsn, de;
        if (ok_full) begin
            model(t_full, 640, 16, 96, 48, 480, 10, 2, 33, h, v, hsn, vsn, de);
            check("full.hpos", 32'(vf.hpos), h);
            check("full.vpos", 32'(vf.vpos), v);
            check("full.hsync", 32'(vf.hsync), 32'(hsn));
            check("full.vsync", 32'(vf.vsync), 32'(vsn));
            check("full.display_on", 32'(vf.display_on), 32'(de));
        end
        if (ok_small) begin
            model(t_small, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, h, v, hsn, vsn, de);
            check("small.hpos", 32'(vs.hpos), h);
            check("small.vpos", 32'(vs.vpos), v);
            check("small.hsync", 32'(vs.hsync), 32'(hsn));
            check("small.vsync", 32'(vs.vsync), 32'(vsn));
            check("small.display_on", 32'(vs.display_on), 32'(de));
        end
    end

    initial begin
        int hs_low;
        int n;
        int strobes;
        int first_strobe;
        int last_strobe;
        int gap_bad;
        int vs_low;
        int vs_run;
        int vs_run_max;
        int de_bad;
        int vs_bad;
        logic prev_vs;

        rst_full_n  = 1'b0;
        rst_small_n = 1'b0;
        repeat (5) @(negedge clk);

        // Reset hold: beam parked at (0,0), syncs idle, display_on decodes as visible.
        check("rst.hpos", 32'(vf.hpos), 0);
        check("rst.vpos", 32'(vf.vpos), 0);
        check("rst.hsync", 32'(vf.hsync), 1);
        check("rst.vsync", 32'(vf.vsync), 1);
        check("rst.display_on", 32'(vf.display_on), 1);

        rst_full_n  = 1'b1;
        rst_small_n = 1'b1;
        @(negedge clk);
        check("release.hpos", 32'(vf.hpos), 1);
        check("release.vpos", 32'(vf.vpos), 0);

        // First line of the full instance, hpos 2..799 then wrap to 0.
        hs_low = 0;
        for (int i = 2; i <= 800; i++) begin
            @(negedge clk);
            if (vf.hsync === 1'b0) hs_low++;
            case (i)
                639: check("line.de@639", 32'(vf.display_on), 1);
                640: check("line.de@640", 32'(vf.display_on), 0);
                655: check("line.hsync@655", 32'(vf.hsync), 1);
                656: check("line.hsync@656", 32'(vf.hsync), 0);
                751: check("line.hsync@751", 32'(vf.hsync), 0);
                752: check("line.hsync@752", 32'(vf.hsync), 1);
                799: check("line.hpos@799", 32'(vf.hpos), 799);
                default: ;
            endcase
        end
        check("line.wrap.hpos", 32'(vf.hpos), 0);
        check("line.wrap.vpos", 32'(vf.vpos), 1);
        check("line.hsync_low_clocks", 32'(hs_low), 96);

        // Mid-frame reset on the full instance at (700,2).
        n = 0;
        while (!(vf.hpos == 10'd700 && vf.vpos == 10'd2) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("midrst.reach_hpos", 32'(vf.hpos), 700);
        rst_full_n = 1'b0;
        @(negedge clk);
        rst_full_n = 1'b1;
        check("midrst.hpos", 32'(vf.hpos), 0);
        check("midrst.vpos", 32'(vf.vpos), 0);
        check("midrst.hsync", 32'(vf.hsync), 1);
        check("midrst.vsync", 32'(vf.vsync), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vf.hpos != 10'd0 && n < 2000);
        check("midrst.line_period", 32'(n), 800);
        check("midrst.next_vpos", 32'(vf.vpos), 1);

        // Scaled instance: reset mid-frame at (25,10), then watch three whole frames.
        n = 0;
        while (!(vs.hpos == 10'd25 && vs.vpos == 10'd10) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("s.midrst.reach_vpos", 32'(vs.vpos), 10);
        rst_small_n = 1'b0;
        @(negedge clk);
        rst_small_n = 1'b1;
        check("s.midrst.hpos", 32'(vs.hpos), 0);
        check("s.midrst.vpos", 32'(vs.vpos), 0);
        check("s.midrst.syncs", 32'({vs.hsync, vs.vsync}), 3);

        strobes = 0; first_strobe = -1; last_strobe = -1; gap_bad = 0;
        vs_low = 0; vs_run = 0; vs_run_max = 0; de_bad = 0; vs_bad = 0;
        prev_vs = vs.vsync;
        for (int c = 1; c <= 3 * int'(S_FRAME); c++) begin
            @(negedge clk);
            if (vs.hpos == 10'd0 && vs.vpos == 10'd0) begin
                strobes++;
                if (first_strobe < 0) first_strobe = c;
                else if (c - last_strobe != int'(S_FRAME)) gap_bad++;
                last_strobe = c;
                if (strobes == 1) begin
                    check("s.dwrap.hsync", 32'(vs.hsync), 1);
                    check("s.dwrap.vsync", 32'(vs.vsync), 1);
                    check("s.dwrap.display_on", 32'(vs.display_on), 1);
                end
            end
            if (vs.vpos >= 10'd8 && vs.display_on !== 1'b0) de_bad++;
            if (vs.vsync === 1'b0) begin
                vs_low++;
                vs_run++;
                if (vs_run > vs_run_max) vs_run_max = vs_run;
                if (vs.vpos != 10'd11 && vs.vpos != 10'd12) vs_bad++;
            end else begin
                vs_run = 0;
            end
            if (prev_vs === 1'b1 && vs.vsync === 1'b0 && c < int'(S_FRAME)) begin
                check("s.vsync_fall.hpos", 32'(vs.hpos), 0);
                check("s.vsync_fall.vpos", 32'(vs.vpos), 11);
            end
            prev_vs = vs.vsync;
        end
        check("s.strobe_count", 32'(strobes), 3);
        check("s.first_strobe_clock", 32'(first_strobe), 510);
        check("s.strobe_spacing_errors", 32'(gap_bad), 0);
        check("s.vsync_low_total", 32'(vs_low), 180);
        check("s.vsync_low_run", 32'(vs_run_max), 60);
        check("s.vsync_outside_lines", 32'(vs_bad), 0);
        check("s.display_below_480eq", 32'(de_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog for the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
